branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32I pipeline. In IF it predicts taken/not-taken and a target for the fetch PC. In EX it takes the resolved branch outcome from the branch comparator, updates its tables, and raises a one-cycle redirect/flush request on misprediction. It also keeps free-running branch and mispredict performance counters.

---
 rtl/branch_predictor.sv | 162 ++++++++++++++++
 tb/tb_branch_predictor.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// for the RV32I pipeline.
//   IF side : combinational taken/target prediction for the fetch PC.
//   EX side : resolves one conditional branch per cycle. It updates the tables
//             and raises a single-cycle redirect request on a misprediction.
//   Perf    : free-running resolved-branch and mispredict counters.
//
// Resolve qualifier: a resolve event occurs in any cycle where
// ex_valid_i && ex_is_branch_i is high. There is no ready/backpressure. Each
// event is consumed at the rising edge that ends the cycle. The pipeline
// guarantees at most one event per instruction.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   if_pc_i            fetch PC to predict
//   pred_taken_o       predicted taken for if_pc_i
//   pred_target_o      predicted target (if_pc_i + 4 on a miss)
//   ex_valid_i         EX holds a live, non-flushed instruction
//   ex_is_branch_i     EX instruction is a conditional branch
//   ex_pc_i            PC of the EX instruction
//   ex_target_i        computed branch target
//   ex_taken_i         resolved branch outcome
//   ex_pred_taken_i    prediction made for this instruction in IF
//   ex_pred_target_i   predicted target made in IF
//   mispredict_o       redirect/flush request (combinational)
//   redirect_pc_o      correct next PC, meaningful when mispredict_o = 1
//   branch_cnt_o       resolved-branch count (registered)
//   mispredict_cnt_o   mispredict count (registered)
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`DATA_WIDTH-1:0] if_pc_i,
  output logic                   pred_taken_o,
  output logic [`DATA_WIDTH-1:0] pred_target_o,
  input  logic                   ex_valid_i,
  input  logic                   ex_is_branch_i,
  input  logic [`DATA_WIDTH-1:0] ex_pc_i,
  input  logic [`DATA_WIDTH-1:0] ex_target_i,
  input  logic                   ex_taken_i,
  input  logic                   ex_pred_taken_i,
  input  logic [`DATA_WIDTH-1:0] ex_pred_target_i,
  output logic                   mispredict_o,
  output logic [`DATA_WIDTH-1:0] redirect_pc_o,
  output logic [`DATA_WIDTH-1:0] branch_cnt_o,
  output logic [`DATA_WIDTH-1:0] mispredict_cnt_o
);

  localparam int DW    = `DATA_WIDTH;
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = DW - IDX - 2;

  localparam logic [DW-1:0] PC_STEP  = DW'(4);
  localparam logic [DW-1:0] CNT_STEP = DW'(1);

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  // Table storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [DW-1:0]    target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [DW-1:0] branch_cnt_q;
  logic [DW-1:0] mispredict_cnt_q;

  // IF-side lookup. pc[1:0] is ignored, so index starts at bit 2.
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc_i[IDX+1:2];
  assign if_tag = if_pc_i[DW-1:IDX+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Lookups always read stored state. A same-cycle update to the same index is
  // not bypassed, so the lookup returns the pre-update entry.
  assign pred_taken_o  = if_hit && ctr_q[if_idx][1];
  assign pred_target_o = if_hit ? target_q[if_idx] : (if_pc_i + PC_STEP);

  // EX-side resolve
  logic             resolve;
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             dir_wrong;
  logic             tgt_wrong;

  assign resolve = ex_valid_i && ex_is_branch_i;
  assign ex_idx  = ex_pc_i[IDX+1:2];
  assign ex_tag  = ex_pc_i[DW-1:IDX+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A correct taken direction still mispredicts if fetch went to the wrong
  // target. When the branch is not taken, the predicted target is irrelevant.
  assign dir_wrong = (ex_taken_i != ex_pred_taken_i);
  assign tgt_wrong = ex_taken_i && (ex_pred_target_i != ex_target_i);

  assign mispredict_o  = resolve && (dir_wrong || tgt_wrong);
  assign redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + PC_STEP);

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) nxt = ctr + 2'b01;
    end else begin
      if (ctr != CTR_MIN) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Table and performance-counter state. Async reset clears everything at
  // once, so an update pending in the reset cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (resolve) begin
      branch_cnt_q <= branch_cnt_q + CNT_STEP;
      if (mispredict_o) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_STEP;
      end

      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next(ctr_q[ex_idx], ex_taken_i);
        if (ex_taken_i) begin
          target_q[ex_idx] <= ex_target_i;
        end
      end else if (ex_taken_i) begin
        // Replace whatever occupied this slot. A not-taken miss leaves the
        // table alone, so never-taken branches do not evict useful entries.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target_i;
        ctr_q[ex_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed scenarios plus randomized resolves for branch_predictor (16
// entries). The reference model keeps each entry as the full PC of the branch
// that allocated it and an integer confidence clamped to 0..3. Index and tag
// come from plain division of the PC.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_taken_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model
  bit          m_valid  [N];
  logic [31:0] m_pc     [N];
  logic [31:0] m_target [N];
  int          m_conf   [N];
  logic [31:0] m_branches;
  logic [31:0] m_mispredicts;

  branch_predictor #(.ENTRIES(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc_i          (if_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_pc_i          (ex_pc_i),
    .ex_target_i      (ex_target_i),
    .ex_taken_i       (ex_taken_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && ((m_pc[s] / (4 * N)) == (pc / (4 * N)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i]  = 1'b0;
      m_pc[i]     = 32'h0;
      m_target[i] = 32'h0;
      m_conf[i]   = 1;
    end
    m_branches    = 32'h0;
    m_mispredicts = 32'h0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int s;
    s  = slot_of(pc);
    tk = model_hit(pc) && (m_conf[s] >= 2);
    tg = model_hit(pc) ? m_target[s] : pc + 32'd4;
  endtask

  task automatic model_resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input bit mp);
    int s;
    s = slot_of(pc);
    m_branches = m_branches + 32'd1;
    if (mp) m_mispredicts = m_mispredicts + 32'd1;
    if (model_hit(pc)) begin
      m_conf[s] = tk ? ((m_conf[s] < 3) ? m_conf[s] + 1 : 3) : ((m_conf[s] > 0) ? m_conf[s] - 1 : 0);
      if (tk) m_target[s] = tgt;
    end else if (tk) begin
      m_valid[s]  = 1'b1;
      m_pc[s]     = pc;
      m_target[s] = tgt;
      m_conf[s]   = 2;
    end
  endtask

  // Driver tasks

  // Drive one EX cycle. The current if_pc_i lookup is checked against the
  // pre-update model. Mispredict and redirect are checked combinationally, and
  // the counters are checked after the edge.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic vld, input logic br, input string name);
    bit          u;
    bit          e_mp;
    logic [31:0] e_rd;
    logic        e_pt;
    logic [31:0] e_ptg;
    @(negedge clk);
    ex_valid_i       = vld;
    ex_is_branch_i   = br;
    ex_pc_i          = pc;
    ex_target_i      = tgt;
    ex_taken_i       = tk;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptgt;
    #1;
    u    = vld && br;
    e_mp = u && ((tk != ptk) || (tk && (ptgt != tgt)));
    e_rd = tk ? tgt : pc + 32'd4;
    model_predict(if_pc_i, e_pt, e_ptg);
    checks++;
    if (mispredict_o !== e_mp) begin
      errors++;
      $display("FAIL %s mispredict_o got %0b exp %0b", name, mispredict_o, e_mp);
    end
    checks++;
    if (redirect_pc_o !== e_rd) begin
      errors++;
      $display("FAIL %s redirect_pc_o got %h exp %h", name, redirect_pc_o, e_rd);
    end
    checks++;
    if (pred_taken_o !== e_pt || pred_target_o !== e_ptg) begin
      errors++;
      $display("FAIL %s same_cycle_lookup pc %h got %0b/%h exp %0b/%h", name, if_pc_i,
               pred_taken_o, pred_target_o, e_pt, e_ptg);
    end
    @(posedge clk);
    if (u) model_resolve(pc, tgt, tk, e_mp);
    #1;
    ex_valid_i = 1'b0;
    checks++;
    if (branch_cnt_o !== m_branches || mispredict_cnt_o !== m_mispredicts) begin
      errors++;
      $display("FAIL %s counters got %0d/%0d exp %0d/%0d", name, branch_cnt_o,
               mispredict_cnt_o, m_branches, m_mispredicts);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input string name);
    logic        e_pt;
    logic [31:0] e_ptg;
    @(negedge clk);
    if_pc_i = pc;
    #1;
    model_predict(pc, e_pt, e_ptg);
    checks++;
    if (pred_taken_o !== e_pt || pred_target_o !== e_ptg) begin
      errors++;
      $display("FAIL %s lookup pc %h got %0b/%h exp %0b/%h", name, pc,
               pred_taken_o, pred_target_o, e_pt, e_ptg);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    ex_valid_i = 1'b0; ex_is_branch_i = 1'b0; ex_pc_i = '0; ex_target_i = '0;
    ex_taken_i = 1'b0; ex_pred_taken_i = 1'b0; ex_pred_target_i = '0; if_pc_i = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lookup(32'h100, "reset");
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin
      errors++;
      $display("FAIL reset_const got %0b/%h exp 0/00000104", pred_taken_o, pred_target_o);
    end
    checks++;
    if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_allocate();
    resolve(32'h100, 32'h200, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1, "alloc");
    lookup(32'h100, "alloc_after");
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h200 ||
        branch_cnt_o !== 32'd1 || mispredict_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL alloc_const got %0b/%h cnt %0d/%0d exp 1/00000200 cnt 1/1",
               pred_taken_o, pred_target_o, branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, "sat_taken");
      lookup(32'h100, "sat_taken_lookup");
    end
    resolve(32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, "sat_nt1");
    lookup(32'h100, "sat_nt1_lookup");
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_still_taken got %0b exp 1", pred_taken_o);
    end
    resolve(32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, "sat_nt2");
    lookup(32'h100, "sat_nt2_lookup");
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_now_not_taken got %0b exp 0", pred_taken_o);
    end
    // Restore a taken entry for the alias scenario.
    resolve(32'h100, 32'h200, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1, "sat_restore");
  endtask

  task automatic test_alias();
    resolve(32'h140, 32'h500, 1'b1, 1'b0, 32'h144, 1'b1, 1'b1, "alias");
    lookup(32'h100, "alias_old");
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin
      errors++;
      $display("FAIL alias_evicted got %0b/%h exp 0/00000104", pred_taken_o, pred_target_o);
    end
    lookup(32'h140, "alias_new");
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h500) begin
      errors++;
      $display("FAIL alias_hit got %0b/%h exp 1/00000500", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_no_update();
    if_pc_i = 32'h140;
    resolve(32'h140, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, "invalid");
    resolve(32'h140, 32'h900, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "not_branch");
    lookup(32'h140, "no_update_lookup");
    resolve(32'h300, 32'h700, 1'b0, 1'b0, 32'h304, 1'b1, 1'b1, "nt_miss");
    lookup(32'h300, "nt_miss_lookup");
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h304) begin
      errors++;
      $display("FAIL nt_miss_alloc got %0b/%h exp 0/00000304", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle();
    // The lookup of 0x380 in the cycle it is allocated must still miss.
    if_pc_i = 32'h380;
    resolve(32'h380, 32'h1000, 1'b1, 1'b0, 32'h384, 1'b1, 1'b1, "same_cycle");
    lookup(32'h380, "same_cycle_after");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        ptk;
    logic [31:0] ptg;
    for (int n = 0; n < 300; n++) begin
      pc = ({$urandom_range(0, 3)} << 6) | ({$urandom_range(0, 15)} << 2) | {$urandom_range(0, 3)};
      if ($urandom_range(0, 7) == 0) pc = pc | 32'h8000_0000;
      tgt = {$urandom_range(0, 255)} << 2;
      tk  = 1'($urandom_range(0, 1));
      model_predict(pc, ptk, ptg);
      if ($urandom_range(0, 3) == 0) begin
        ptk = 1'($urandom_range(0, 1));
        ptg = {$urandom_range(0, 255)} << 2;
      end
      if_pc_i = ({$urandom_range(0, 3)} << 6) | ({$urandom_range(0, 15)} << 2);
      resolve(pc, tgt, tk, ptk, ptg, 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 7) != 0), "random");
    end
  endtask

  task automatic test_mid_reset();
    resolve(32'h100, 32'h200, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1, "pre_rst_a");
    resolve(32'h208, 32'h400, 1'b1, 1'b0, 32'h20c, 1'b1, 1'b1, "pre_rst_b");
    @(negedge clk);
    if_pc_i    = 32'h208;
    rst        = 1'b1;
    ex_valid_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h20c) begin
      errors++;
      $display("FAIL mid_rst_lookup got %0b/%h exp 0/0000020c", pred_taken_o, pred_target_o);
    end
    checks++;
    if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_counters got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lookup(32'h100, "post_rst_a");
    lookup(32'h208, "post_rst_b");
    resolve(32'h208, 32'h400, 1'b1, 1'b0, 32'h20c, 1'b1, 1'b1, "post_rst_resolve");
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturate();
    test_alias();
    test_no_update();
    test_same_cycle();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
